// File: rtl/sa_pe_pkg.sv
// Shared helpers for the multi-lane systolic PE: saturation arithmetic, lane slicing,
// operand gating compare and the accumulator width legality rule.
package sa_pe_pkg;

  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic int oc_w_min(input int ia_w, input int ib_w, input int lanes);
    return ia_w + ib_w + $clog2(lanes) + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // A lane is gated when either operand is zero or |a| falls under the threshold.
  function automatic logic lane_gated(input logic signed [31:0] a,
                                      input logic signed [31:0] b,
                                      input logic [31:0]        thres);
    logic [31:0] mag;
    mag = a[31] ? 32'(-a) : 32'(a);
    return (a == 32'sd0) || (b == 32'sd0) || (mag < thres);
  endfunction

  function automatic wide_t sat_hi(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic wide_t sat_lo(input int unsigned w);
    return -sat_hi(w) - 64'sd1;
  endfunction

  // Signed add clamped to a w-bit two's complement range.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    s = a + b;
    if (s > sat_hi(w)) return sat_hi(w);
    if (s < sat_lo(w)) return sat_lo(w);
    return s;
  endfunction

  function automatic logic sat_clips(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    s = a + b;
    return (s > sat_hi(w)) || (s < sat_lo(w));
  endfunction

endpackage

// File: rtl/sa_pe_lane_mul.sv
// One MAC lane: zero/threshold detect, operand-hold registers (gated lanes freeze their
// multiplier inputs) and a signed multiplier. Product is valid one enabled cycle after capture.
module sa_pe_lane_mul
  import sa_pe_pkg::*;
#(
  parameter int IA_W = 8,
  parameter int IB_W = 8,
  parameter int TH_W = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic signed [IA_W-1:0]        a_i,
  input  logic signed [IB_W-1:0]        b_i,
  input  logic        [TH_W-1:0]        thres_i,
  output logic signed [IA_W+IB_W-1:0]   prod_o
);

  localparam int PROD_W = IA_W + IB_W;

  logic signed [IA_W-1:0] a_q;
  logic signed [IB_W-1:0] b_q;
  logic                   gated_q;
  logic                   gate_d;

  assign gate_d = lane_gated(32'(a_i), 32'(b_i), 32'(thres_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      gated_q <= 1'b0;
    end else if (en_i) begin
      gated_q <= gate_d;
      if (!gate_d) begin
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end

  assign prod_o = gated_q ? '0 : PROD_W'(a_q) * PROD_W'(b_q);

endmodule

// File: rtl/sa_pe_mlane.sv
// Multi-lane systolic PE: LANES-wide gated dot product into a saturating accumulator with a
// double-buffered shadow drained over the scan chain; every register freezes when i_pipeline_en=0.
module sa_pe_mlane
  import sa_pe_pkg::*;
#(
  parameter int IA_W  = 8,
  parameter int IB_W  = 8,
  parameter int OC_W  = 24,
  parameter int LANES = 2,
  parameter int TH_W  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [LANES*IA_W-1:0]   i_a,
  input  logic [LANES*IB_W-1:0]   i_b,
  input  logic [OC_W-1:0]         i_c,
  input  logic                    i_reg_clear,
  input  logic                    i_cell_en,
  input  logic                    i_pipeline_en,
  input  logic                    i_cswitch,
  input  logic                    i_cscan_en,
  input  logic [TH_W-1:0]         i_thres,
  output logic [LANES*IA_W-1:0]   o_a,
  output logic [LANES*IB_W-1:0]   o_b,
  output logic [OC_W-1:0]         o_c,
  output logic                    o_cswitch,
  output logic                    o_cell_en,
  output logic                    o_ovf
);

  localparam int PROD_W = IA_W + IB_W;
  localparam int SUM_W  = IA_W + IB_W + $clog2(LANES);

  if (LANES < 1 || OC_W < oc_w_min(IA_W, IB_W, LANES) || OC_W > SAT_W - 2) begin : g_bad_cfg
    $error("sa_pe_mlane: OC_W too narrow for IA_W/IB_W/LANES, or LANES < 1");
  end

  logic [LANES*IA_W-1:0]  a_fwd_q;
  logic [LANES*IB_W-1:0]  b_fwd_q;
  logic                   cswitch_q;
  logic                   cell_en_q;
  logic                   valid_q;
  logic                   tag_q;
  logic signed [OC_W-1:0] acc_q;
  logic signed [OC_W-1:0] acc_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic [OC_W-1:0]        shadow_q;
  logic                   shadow_ovf_q;

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  sum_c;
  wide_t                    base_c;
  wide_t                    addend_c;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sa_pe_lane_mul #(
      .IA_W (IA_W),
      .IB_W (IB_W),
      .TH_W (TH_W)
    ) u_mul (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .en_i    (i_pipeline_en),
      .a_i     (i_a[lane_lo(l, IA_W) +: IA_W]),
      .b_i     (i_b[lane_lo(l, IB_W) +: IB_W]),
      .thres_i (i_thres),
      .prod_o  (prod[l])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_c = sum_c + SUM_W'(prod[l]);
    end
  end

  // A tagged operand opens a fresh context: start from zero and drop the old sticky flag.
  always_comb begin
    base_c   = tag_q ? '0 : SAT_W'(acc_q);
    addend_c = valid_q ? SAT_W'(sum_c) : '0;
    acc_d    = OC_W'(sat_add(base_c, addend_c, OC_W));
    ovf_d    = sat_clips(base_c, addend_c, OC_W) | (ovf_q & ~tag_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_fwd_q      <= '0;
      b_fwd_q      <= '0;
      cswitch_q    <= 1'b0;
      cell_en_q    <= 1'b0;
      valid_q      <= 1'b0;
      tag_q        <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_ovf_q <= 1'b0;
    end else if (i_pipeline_en) begin
      a_fwd_q   <= i_a;
      b_fwd_q   <= i_b;
      cswitch_q <= i_cswitch;
      cell_en_q <= i_cell_en;
      if (i_reg_clear) begin
        valid_q <= 1'b0;
        tag_q   <= 1'b0;
        acc_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        valid_q <= i_cell_en;
        tag_q   <= i_cswitch;
        acc_q   <= acc_d;
        ovf_q   <= ovf_d;
        if (tag_q) begin
          shadow_q     <= acc_q;
          shadow_ovf_q <= ovf_q;
        end else if (i_cscan_en) begin
          shadow_q     <= i_c;
          shadow_ovf_q <= 1'b0;
        end
      end
    end
  end

  assign o_a       = a_fwd_q;
  assign o_b       = b_fwd_q;
  assign o_c       = shadow_q;
  assign o_cswitch = cswitch_q;
  assign o_cell_en = cell_en_q;
  assign o_ovf     = shadow_ovf_q;

endmodule

// File: tb/tb_sa_pe_mlane.sv
// Directed bench for sa_pe_mlane at default parameters with hand-computed expectations.
module tb_sa_pe_mlane;

  localparam int IA_W  = 8;
  localparam int IB_W  = 8;
  localparam int OC_W  = 24;
  localparam int LANES = 2;
  localparam int TH_W  = 4;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic [LANES*IA_W-1:0] i_a;
  logic [LANES*IB_W-1:0] i_b;
  logic [OC_W-1:0]       i_c;
  logic                  i_reg_clear;
  logic                  i_cell_en;
  logic                  i_pipeline_en;
  logic                  i_cswitch;
  logic                  i_cscan_en;
  logic [TH_W-1:0]       i_thres;
  logic [LANES*IA_W-1:0] o_a;
  logic [LANES*IB_W-1:0] o_b;
  logic [OC_W-1:0]       o_c;
  logic                  o_cswitch;
  logic                  o_cell_en;
  logic                  o_ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  sa_pe_mlane #(
    .IA_W  (IA_W),
    .IB_W  (IB_W),
    .OC_W  (OC_W),
    .LANES (LANES),
    .TH_W  (TH_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_c           (i_c),
    .i_reg_clear   (i_reg_clear),
    .i_cell_en     (i_cell_en),
    .i_pipeline_en (i_pipeline_en),
    .i_cswitch     (i_cswitch),
    .i_cscan_en    (i_cscan_en),
    .i_thres       (i_thres),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_c           (o_c),
    .o_cswitch     (o_cswitch),
    .o_cell_en     (o_cell_en),
    .o_ovf         (o_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic op(input int a0, input int a1, input int b0, input int b1,
                    input logic en, input logic cs);
    i_a       = {8'(a1), 8'(a0)};
    i_b       = {8'(b1), 8'(b0)};
    i_cell_en = en;
    i_cswitch = cs;
  endtask

  initial begin
    i_rst = 1'b1; i_a = '0; i_b = '0; i_c = '0; i_reg_clear = 1'b0; i_cell_en = 1'b0;
    i_pipeline_en = 1'b1; i_cswitch = 1'b0; i_cscan_en = 1'b0; i_thres = '0;
    #12;
    chk("reset_o_a", 64'(o_a), 64'h0);
    chk("reset_o_c", 64'(o_c), 64'h0);
    chk("reset_flags", 64'({o_cswitch, o_cell_en, o_ovf}), 64'h0);
    i_rst = 1'b0;

    // Basic MAC: 3 x (3*4 + -2*5) = 6, then a switch operand worth 2
    op(3, -2, 4, 5, 1'b1, 1'b0);
    tick();
    chk("fwd_o_a", 64'(o_a), 64'hFE03);
    chk("fwd_o_b", 64'(o_b), 64'h0504);
    chk("fwd_cell_en", 64'(o_cell_en), 64'h1);
    tick();
    tick();
    op(1, 1, 1, 1, 1'b1, 1'b1);
    tick();
    chk("fwd_cswitch", 64'(o_cswitch), 64'h1);
    chk("mac_before_switch", 64'(o_c), 64'h0);
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("mac_ctx0", 64'(o_c), 64'd6);
    chk("mac_acc_new", 64'(dut.acc_q), 64'd2);
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("mac_ctx1", 64'(o_c), 64'd2);

    // Gating: lane 0 (|3| < 4) contributes nothing and keeps its last inputs (1,1)
    i_thres = 4'd4;
    op(3, 10, 7, 2, 1'b1, 1'b0);
    tick();
    chk("gate_l0_a_hold", 64'(dut.g_lane[0].u_mul.a_q), 64'd1);
    chk("gate_l0_b_hold", 64'(dut.g_lane[0].u_mul.b_q), 64'd1);
    chk("gate_l1_a_load", 64'(dut.g_lane[1].u_mul.a_q), 64'd10);
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("gate_sum", 64'(o_c), 64'd20);
    i_thres = 4'd0;

    // Saturation: 261 x 32258 exceeds 2^23-1 on the final add
    op(127, 127, 127, 127, 1'b1, 1'b0);
    repeat (261) tick();
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("sat_value", 64'(o_c), 64'h7FFFFF);
    chk("sat_ovf", 64'(o_ovf), 64'h1);
    chk("sat_next_ovf", 64'(dut.ovf_q), 64'h0);

    i_cscan_en = 1'b1;
    i_c = 24'h00ABCD;
    tick();
    chk("scan_shift", 64'(o_c), 64'h00ABCD);
    chk("scan_ovf_clr", 64'(o_ovf), 64'h0);
    i_cscan_en = 1'b0;
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("sat_next_ctx", 64'({o_ovf, o_c}), 64'h0);

    // Stall: A=23, B=-2, C=-5 -> 16 with freezes mid-stream and with a tag in flight
    op(2, 3, 4, 5, 1'b1, 1'b0);
    tick();
    op(-4, 5, 3, 2, 1'b1, 1'b0);
    tick();
    i_pipeline_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op(9 + k, 9, 9, 9 - k, 1'b1, 1'b1);
      tick();
      chk("stall_o_a", 64'(o_a), 64'h05FC);
      chk("stall_acc", 64'(dut.acc_q), 64'd23);
    end
    i_pipeline_en = 1'b1;
    op(7, -3, 1, 4, 1'b1, 1'b0);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    i_pipeline_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op(5, 6, 7, 8, 1'b1, 1'b0);
      tick();
      chk("stall_tag_o_c", 64'(o_c), 64'h0);
      chk("stall_tag_cswitch", 64'(o_cswitch), 64'h1);
    end
    i_pipeline_en = 1'b1;
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("stall_sum", 64'(o_c), 64'd16);

    // Tag load beats scan shift in the same cycle
    op(1, 1, 2, 2, 1'b1, 1'b0);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    i_cscan_en = 1'b1;
    i_c = 24'h123456;
    tick();
    chk("prio_tag_over_scan", 64'(o_c), 64'd4);
    i_cscan_en = 1'b0;

    // Clear beats a pending tag: no shadow load, accumulator zeroed
    op(2, 2, 3, 3, 1'b1, 1'b0);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    i_reg_clear = 1'b1;
    tick();
    chk("clear_no_load", 64'(o_c), 64'd4);
    chk("clear_acc", 64'(dut.acc_q), 64'd0);
    i_reg_clear = 1'b0;
    op(0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    op(0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("clear_ctx", 64'(o_c), 64'd0);

    // Asynchronous reset with live state
    op(5, 5, 5, 5, 1'b1, 1'b0);
    i_cscan_en = 1'b1;
    i_c = 24'h000777;
    tick();
    chk("pre_reset_o_c", 64'(o_c), 64'h777);
    i_cscan_en = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    chk("async_rst_o_a", 64'(o_a), 64'h0);
    chk("async_rst_o_c", 64'(o_c), 64'h0);
    chk("async_rst_flags", 64'({o_cswitch, o_cell_en, o_ovf}), 64'h0);
    #10;
    i_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
